// File: rtl/chunked_sum_pkg.sv
// chunked_sum_pkg
//   Shared definitions for the chunked_sum block: FSM state encoding and a
//   helper that sizes counters/indices from the number of values they must hold.
//   Optional feature macro used by the block: CHUNKED_SUM_OVF_EN.
package chunked_sum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bits needed to hold the values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/sum_slice.sv
// sum_slice
//   Combinational CHUNK-bit adder with carry in and carry out. The top reuses
//   a single instance for every slice of a multi-cycle operation.
//   Ports:
//     a_i, b_i  CHUNK-bit operand slices
//     c_i       carry into the slice LSB
//     s_o       CHUNK-bit slice sum
//     c_o       carry out of the slice MSB
//     c_msb_o   carry into the slice MSB (only with CHUNKED_SUM_OVF_EN)
module sum_slice #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] s_o,
   output logic             c_o
`ifdef CHUNKED_SUM_OVF_EN
   ,
   output logic             c_msb_o
`endif
);

   logic [CHUNK:0] sum_full;

   // Widened add so the slice carry-out lands in the top bit.
   always_comb begin
      sum_full = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
   end

   assign s_o = sum_full[CHUNK-1:0];
   assign c_o = sum_full[CHUNK];

`ifdef CHUNKED_SUM_OVF_EN
   // Sum bit = a ^ b ^ carry-in at the MSB, so the incoming carry is recovered by XOR.
   assign c_msb_o = sum_full[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_sum.sv
// chunked_sum
//   Multi-cycle WIDTH-bit adder/subtractor working CHUNK bits per clock, with
//   the carry held in a flop between slices. Operands arrive on a valid/ready
//   handshake, the result leaves on a valid/ready handshake; no overlap.
//   Subtraction is a + ~b + ~ci, so co=1 means "no borrow".
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//     a, b, ci, sub        operands, carry/borrow-in, 0:add 1:subtract
//     out_valid/out_ready  result handshake (out_valid high only in DONE)
//     sum, co              result mod 2^WIDTH and carry-out / not-borrow
//     busy                 high in RUN or DONE
//     ovf                  signed overflow, present only with CHUNKED_SUM_OVF_EN
//   Timing: slices are added on the NSLICE edges after the accepting edge,
//   one further edge commits co/ovf and raises out_valid (NSLICE+1 edges).
module chunked_sum
   import chunked_sum_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             busy
`ifdef CHUNKED_SUM_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW     = cnt_width(NSLICE + 1);
   localparam int IW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_COMMIT = CW'(NSLICE);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_sum: WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [IW-1:0]    base;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] slice_s;
   logic             carry_d;

`ifdef CHUNKED_SUM_OVF_EN
   logic             cmsb_d;
   logic             cmsb_q;
   logic             ovf_q;
`endif

   // Bit offset of the current slice; clamped to 0 on the commit cycle so the select stays in range.
   always_comb begin
      if (cnt_q < CNT_COMMIT) begin
         base = IW'(int'(cnt_q) * CHUNK);
      end else begin
         base = '0;
      end
      a_sl = a_q[base +: CHUNK];
      b_sl = b_q[base +: CHUNK];
   end

   sum_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_i     (a_sl),
      .b_i     (b_sl),
      .c_i     (carry_q),
      .s_o     (slice_s),
      .c_o     (carry_d)
`ifdef CHUNKED_SUM_OVF_EN
      ,
      .c_msb_o (cmsb_d)
`endif
   );

   // Control FSM, operand/sum registers, carry flop, slice counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef CHUNKED_SUM_OVF_EN
         cmsb_q      <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               // in_ready_q is high throughout IDLE, so in_valid alone completes the handshake.
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= sub ? ~b : b;
                  carry_q    <= sub ? ~ci : ci;
                  cnt_q      <= '0;
                  state_q    <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cnt_q == CNT_COMMIT) begin
                  // All slices written; carry_q now holds the carry out of the MSB.
                  co_q        <= carry_q;
`ifdef CHUNKED_SUM_OVF_EN
                  ovf_q       <= cmsb_q ^ carry_q;
`endif
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  sum_q[base +: CHUNK] <= slice_s;
                  carry_q              <= carry_d;
`ifdef CHUNKED_SUM_OVF_EN
                  cmsb_q               <= cmsb_d;
`endif
                  cnt_q                <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q     <= ST_DONE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign co        = co_q;
   assign busy      = busy_q;
`ifdef CHUNKED_SUM_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_sum.sv
// tb_chunked_sum
//   Scoreboard bench for chunked_sum: an 8-bit/2-bit-chunk instance (dut0) and
//   a 5-bit/1-bit-chunk instance (dut1). Expected results come from a plain
//   integer arithmetic model and are queued at acceptance; monitors pop and
//   compare on each result handshake. ovf is checked when CHUNKED_SUM_OVF_EN is set.
module tb_chunked_sum;

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // dut0: WIDTH=8, CHUNK=2
   logic       in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
   logic [7:0] a0 = '0, b0 = '0, sum0;
   logic       ci0 = 1'b0, sub0 = 1'b0, co0, busy0;
   // dut1: WIDTH=5, CHUNK=1
   logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
   logic [4:0] a1 = '0, b1 = '0, sum1;
   logic       ci1 = 1'b0, sub1 = 1'b0, co1, busy1;
`ifdef CHUNKED_SUM_OVF_EN
   logic       ovf0, ovf1;
`endif

   chunked_sum #(.WIDTH(8), .CHUNK(2)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .a(a0), .b(b0), .ci(ci0), .sub(sub0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .sum(sum0), .co(co0), .busy(busy0)
`ifdef CHUNKED_SUM_OVF_EN
      , .ovf(ovf0)
`endif
   );

   chunked_sum #(.WIDTH(5), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .ci(ci1), .sub(sub1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .co(co1), .busy(busy1)
`ifdef CHUNKED_SUM_OVF_EN
      , .ovf(ovf1)
`endif
   );

   int   checks = 0;
   int   failures = 0;
   exp_t exp0[$];
   exp_t exp1[$];
   int   rdy_mode = 1;   // 0: out_ready0 low, 1: high, 2: random

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference: exact integer arithmetic, then reduced to w bits / carry / signed range.
   function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic civ, input logic subv);
      exp_t   e;
      longint m, ua, ub, c, r, sa, sb, sr;
      m  = longint'(1) << w;
      ua = av;
      ub = bv;
      c  = civ;
      r  = subv ? (ua - ub - c) : (ua + ub + c);
      e.s  = 32'(r & (m - 1));
      e.co = subv ? (r >= 0) : (r >= m);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      sr = subv ? (sa - sb - c) : (sa + sb + c);
      e.ov = (sr < -(m / 2)) || (sr >= m / 2);
      return e;
   endfunction

   // out_ready0 driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready0 = 1'b0;
            1:       out_ready0 = 1'b1;
            default: out_ready0 = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // dut0 monitor.
   always @(negedge clk) begin
      if (!rst && out_valid0 && out_ready0) begin
         if (exp0.size() == 0) begin
            chk("dut0_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp0.pop_front();
            chk("dut0_sum", {24'd0, sum0}, e.s);
            chk("dut0_co", {31'd0, co0}, {31'd0, e.co});
`ifdef CHUNKED_SUM_OVF_EN
            chk("dut0_ovf", {31'd0, ovf0}, {31'd0, e.ov});
`endif
         end
      end
   end

   // dut1 monitor.
   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         if (exp1.size() == 0) begin
            chk("dut1_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp1.pop_front();
            chk("dut1_sum", {27'd0, sum1}, e.s);
            chk("dut1_co", {31'd0, co1}, {31'd0, e.co});
`ifdef CHUNKED_SUM_OVF_EN
            chk("dut1_ovf", {31'd0, ovf1}, {31'd0, e.ov});
`endif
         end
      end
   end

   task automatic send0(input logic [7:0] av, input logic [7:0] bv, input logic civ, input logic subv);
      int n = 0;
      a0 = av; b0 = bv; ci0 = civ; sub0 = subv; in_valid0 = 1'b1;
      @(negedge clk);
      while (!in_ready0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready0) chk("dut0_accept_timeout", 32'd0, 32'd1);
      else exp0.push_back(model(8, {24'd0, av}, {24'd0, bv}, civ, subv));
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
   endtask

   task automatic send1(input logic [4:0] av, input logic [4:0] bv, input logic civ, input logic subv);
      int n = 0;
      a1 = av; b1 = bv; ci1 = civ; sub1 = subv; in_valid1 = 1'b1;
      @(negedge clk);
      while (!in_ready1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready1) chk("dut1_accept_timeout", 32'd0, 32'd1);
      else exp1.push_back(model(5, {27'd0, av}, {27'd0, bv}, civ, subv));
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
   endtask

   task automatic drain0();
      int n = 0;
      while ((exp0.size() != 0 || !in_ready0) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp0.size() != 0 || !in_ready0) chk("dut0_drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain1();
      int n = 0;
      while ((exp1.size() != 0 || !in_ready1) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp1.size() != 0 || !in_ready1) chk("dut1_drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] ta[9] = '{8'h05, 8'hFF, 8'h05, 8'h0A, 8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h80};
   logic [7:0] tb[9] = '{8'h0A, 8'h01, 8'h0A, 8'h05, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h01};
   logic       tc[9] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
   logic       ts[9] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};

   initial begin
      int   n;
      logic ok;
      exp_t e4;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dut0_outputs", {22'd0, in_ready0, out_valid0, sum0, co0, busy0}, {22'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      chk("rst_dut1_outputs", {25'd0, in_ready1, out_valid1, sum1, co1, busy1}, {25'd0, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0});
`ifdef CHUNKED_SUM_OVF_EN
      chk("rst_ovf", {30'd0, ovf0, ovf1}, 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1 + 2: latency NSLICE+1 = 5 edges, in_ready low / busy high while waiting
      rdy_mode = 1;
      send0(8'h01, 8'h02, 1'b0, 1'b0);
      n = 0;
      ok = 1'b1;
      while (!out_valid0 && n < 20) begin
         if (in_ready0 || !busy0) ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency_edges", n, 32'd5);
      chk("in_ready_low_busy_high", {31'd0, ok}, 32'd1);
      drain0();

      // Directed add/sub and wrap-around cases
      for (int i = 0; i < 9; i++) begin
         send0(ta[i], tb[i], tc[i], ts[i]);
         drain0();
      end

      // Hold the result in DONE for 10 cycles with in_valid pulses
      rdy_mode = 0;
      e4 = model(8, 32'h3C, 32'hD9, 1'b1, 1'b0);
      send0(8'h3C, 8'hD9, 1'b1, 1'b0);
      n = 0;
      while (!out_valid0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid0 = i[0];
         a0 = 8'($urandom);
         b0 = 8'($urandom);
         @(posedge clk);
         #1;
         if (!out_valid0 || in_ready0 || sum0 !== e4.s[7:0] || co0 !== e4.co) ok = 1'b0;
      end
      chk("done_hold_stable", {31'd0, ok}, 32'd1);
      in_valid0 = 1'b0;
      rdy_mode = 1;
      drain0();
      send0(8'h21, 8'h12, 1'b0, 1'b0);
      drain0();

      // Reset in the middle of RUN (slice 2)
      send0(8'hA5, 8'h3C, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrun_rst_outputs", {22'd0, in_ready0, out_valid0, sum0, co0, busy0}, {22'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      void'(exp0.pop_back());
      @(posedge clk);
      #1;
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid0) ok = 1'b0;
      end
      chk("no_result_after_rst", {31'd0, ok}, 32'd1);
      send0(8'h64, 8'h9C, 1'b0, 1'b1);
      drain0();

      // Random back-to-back operations with random out_ready
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         send0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rdy_mode = 1;
      drain0();

      // 5-bit, 1-bit chunk instance
      send1(5'd1, 5'd2, 1'b0, 1'b0);
      send1(5'd5, 5'd10, 1'b0, 1'b0);
      send1(5'd5, 5'd10, 1'b1, 1'b0);
      send1(5'd31, 5'd1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         send1(5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain1();

      chk("dut0_queue_empty", exp0.size(), 32'd0);
      chk("dut1_queue_empty", exp1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
